rho_prime_reader: RTL and testbench
===================================

# rho_prime_reader

Read-side companion to the ExpandS `Rho_prime` data memory (8 × 64-bit BRAM). On `start`, it reads the 64-byte seed ρ′ word by word and appends the 16-bit ExpandS nonce `r`. It then streams the SHAKE256 absorb block to the Keccak absorber over a valid/ready interface, with full backpressure tolerance and one-word-per-cycle sustained throughput.

## Interface
Parameters:
- `DLEN`, 64: word width; fixed to the Keccak lane width.
- `HLEN`, 3: BRAM address width; the seed occupies 2^HLEN words.

Ports:
- `clk`  in  1  single clock; everything is on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `start`  in  1  single-cycle request; sampled only while idle.
- `nonce`  in  16  ExpandS row index `r`; latched when `start` is accepted.
- `busy`  out  1  high from start acceptance through the final handshake.
- `done`  out  1  one-cycle pulse in the cycle after the final handshake.
- `Rho_prime_raddr`  out  HLEN  BRAM read address.
- `Rho_prime_dout`  in  DLEN  BRAM read data, valid exactly 1 cycle after `raddr`.
- `blk_word`  out  DLEN  absorb word (little-endian lane).
- `blk_idx`  out  5  index of `blk_word` within the block.
- `blk_valid`  out  1  word valid.
- `blk_ready`  in  1  absorber accepts the word; a handshake is `blk_valid & blk_ready`.
- `blk_last`  out  1  marks the final word of the block.

## Operation
- FSM states:
  - IDLE: on `start`, latch `nonce`, go to READ.
  - READ: issue addresses 0..7.
  - TAIL: generate synthetic words (nonce and padding).
  - DRAIN: wait for the final handshake, then pulse `done` and return to IDLE.
- Word map with padding compiled in (17 words = SHAKE256 rate of 136 bytes):
  - words 0–7: ρ′ words 0–7 unchanged; byte 0 of ρ′ sits in bits [7:0].
  - word 8: bits[15:0] = `nonce` (low byte first), bits[23:16] = 0x1F, all other bits 0.
  - words 9–15: zero.
  - word 16: bits[63:56] = 0x80, all other bits 0.
- Output path is a 2-entry skid buffer.
  - A BRAM read issues only when (free slots − reads in flight) > 0.
  - `Rho_prime_dout` is captured unconditionally in the cycle after issue.
  - Synthetic words enter the buffer through the same path, with no BRAM access.
- While `blk_valid` is high and `blk_ready` is low, `blk_word`, `blk_idx` and `blk_last` hold stable.
- `start` is ignored while `busy` is high.
- `nonce` changes after acceptance have no effect.
- Reset mid-operation: immediately return to IDLE; buffer emptied; in-flight reads discarded.

## Timing
- Reset values: `busy`=0, `done`=0, `blk_valid`=0, `blk_last`=0, `blk_word`=0, `blk_idx`=0, `Rho_prime_raddr`=0.
- With `start` accepted at edge E0:
  - `busy` is high from the cycle after E0.
  - `raddr`=0 is driven in cycle 1; word 0 is captured at E2.
  - `blk_valid` is first high in cycle 2.
- With `blk_ready` held high:
  - one word per cycle, indices 0..16 in cycles 2..18.
  - `blk_last` is high in cycle 18; `done` pulses in cycle 19 while `busy` falls.
  - total latency from start to done is 19 cycles.
- Under backpressure:
  - no word is dropped or duplicated, and addresses are never skipped.
  - at most 2 words are buffered, so reads in flight plus buffered words never exceed 2.
- A `start` in the same cycle as `done` is ignored.

## Configuration
- `RHO_READER_PAD_EN` defined: emit the full 17-word padded block as above; `blk_last` is on word 16.
- `RHO_READER_PAD_EN` undefined:
  - emit only 9 words; word 8 = {48'b0, `nonce`}, with no 0x1F byte.
  - `blk_last` is on word 8; the absorber applies the padding.
  - `done` pulses in cycle 11.

## Structure
- Shared package `expands_pkg`: `RHO_WORDS`=8, `RATE_WORDS`=17, `SHAKE256_DS`=8'h1F, `PAD_END`=8'h80, and the FSM state enum.
- Sub-module `rho_skid_buf`: 2-entry valid/ready buffer carrying {word, idx, last} and reporting a free-slot count.

## Test plan
- ρ′ words = 64'h0706050403020100 + i·64'h0808080808080808, `nonce`=16'h0102, ready always high → words 0–7 match memory; word 8 = 64'h0000_0000_001F_0102; words 9–15 = 0; word 16 = 64'h8000_0000_0000_0000; `done` in cycle 19.
- Same data, `blk_ready` toggling 1-0-1-0 → identical 17-word sequence; outputs stable during stalls; never more than 2 reads ahead.
- `blk_ready` low for 20 cycles after start → exactly 2 words buffered, `raddr` frozen; release → seamless 0..16 sequence.
- `start` pulsed at cycle 5 and again with `nonce`=16'hFFFF mid-block → ignored; the original nonce is emitted.
- `reset` asserted at word 10 → all outputs return to reset values at once; a fresh `start` then reproduces the full block.
- Build without `RHO_READER_PAD_EN`, `nonce`=16'h0304 → 9 words, last = 64'h0000_0000_0000_0304 with `blk_last`, `done` in cycle 11.

Source files
------------

// File: rtl/expands_pkg.sv
// rtl/expands_pkg.sv - shared ExpandS constants and reader FSM state type
//
// Constants shared by the ExpandS seed reader:
//   RHO_WORDS   : 64-bit words in the rho' seed
//   RATE_WORDS  : SHAKE256 rate in 64-bit lanes (136 bytes)
//   SHAKE256_DS : domain-separation byte following the message
//   PAD_END     : final padding bit, top byte of the last rate lane
//   IDX_W       : width of the in-block word index
package expands_pkg;

    localparam int RHO_WORDS = 8;
    localparam int RATE_WORDS = 17;
    localparam int IDX_W = 5;
    localparam logic [7:0] SHAKE256_DS = 8'h1F;
    localparam logic [7:0] PAD_END = 8'h80;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_TAIL  = 2'd2,
        ST_DRAIN = 2'd3
    } rd_state_t;

endpackage

// File: rtl/rho_skid_buf.sv
// rtl/rho_skid_buf.sv - 2-entry valid/ready output buffer for absorb words
//
// Holds up to two {word, idx, last} entries. The head entry drives the
// outputs directly from registers, so they stay stable while stalled.
// Ports:
//   clk, reset           : clock, asynchronous active-low reset
//   push, push_*         : unconditional write of one entry (caller
//                          guarantees a free slot)
//   out_word/idx/last    : head entry
//   out_valid, out_ready : downstream handshake
//   free                 : number of empty slots (0..2)
module rho_skid_buf #(
    parameter int DLEN = 64,
    parameter int IW = 5
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            push,
    input  logic [DLEN-1:0] push_word,
    input  logic [IW-1:0]   push_idx,
    input  logic            push_last,
    output logic [DLEN-1:0] out_word,
    output logic [IW-1:0]   out_idx,
    output logic            out_last,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [1:0]      free
);

    localparam int EW = DLEN + IW + 1;

    logic [EW-1:0] in_e;
    logic [EW-1:0] head_q;
    logic [EW-1:0] tail_q;
    logic [1:0]    count_q;
    logic          pop;

    assign in_e = {push_word, push_idx, push_last};
    assign out_valid = (count_q != 2'd0);
    assign pop = out_valid & out_ready;
    assign free = 2'd2 - count_q;
    assign {out_word, out_idx, out_last} = head_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= 2'd0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (count_q == 2'd0) begin
                        head_q  <= in_e;
                        count_q <= 2'd1;
                    end else if (count_q == 2'd1) begin
                        tail_q  <= in_e;
                        count_q <= 2'd2;
                    end
                end
                2'b01: begin
                    head_q  <= tail_q;
                    count_q <= count_q - 2'd1;
                end
                2'b11: begin
                    // Count is unchanged; the new entry lands behind
                    // whatever remains after the pop.
                    if (count_q == 2'd1) begin
                        head_q <= in_e;
                    end else begin
                        head_q <= tail_q;
                        tail_q <= in_e;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: rtl/rho_prime_reader.sv
// rtl/rho_prime_reader.sv - streams rho' seed plus nonce as a SHAKE256 absorb block
//
// Reads the 8-word rho' seed from BRAM, appends the 16-bit ExpandS nonce
// and streams the absorb block word by word over valid/ready.
// Build option RHO_READER_PAD_EN: when defined, the full padded 17-word
// rate block is emitted; otherwise only 9 words (seed + nonce) are sent.
// Ports:
//   clk, reset        : clock, asynchronous active-low reset
//   start, nonce      : block request and row index r (latched on accept)
//   busy, done        : activity flag, one-cycle completion pulse
//   Rho_prime_raddr   : BRAM read address
//   Rho_prime_dout    : BRAM data, one cycle after the address
//   blk_word/idx/last : absorb word, its index, final-word marker
//   blk_valid/ready   : absorb handshake
module rho_prime_reader
    import expands_pkg::*;
#(
    parameter int DLEN = 64,
    parameter int HLEN = 3
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [15:0]     nonce,
    output logic            busy,
    output logic            done,
    output logic [HLEN-1:0] Rho_prime_raddr,
    input  logic [DLEN-1:0] Rho_prime_dout,
    output logic [DLEN-1:0] blk_word,
    output logic [4:0]      blk_idx,
    output logic            blk_valid,
    input  logic            blk_ready,
    output logic            blk_last
);

    localparam int SEED_WORDS = 1 << HLEN;
`ifdef RHO_READER_PAD_EN
    localparam int BLK_WORDS = RATE_WORDS;
`else
    localparam int BLK_WORDS = SEED_WORDS + 1;
`endif
    localparam logic [4:0] SEED_LAST = 5'(SEED_WORDS - 1);
    localparam logic [4:0] NONCE_IDX = 5'(SEED_WORDS);
    localparam logic [4:0] LAST_IDX  = 5'(BLK_WORDS - 1);

    rd_state_t       state_q;
    rd_state_t       state_d;
    logic [4:0]      issue_idx_q;
    logic            inflight_q;
    logic [4:0]      inflight_idx_q;
    logic [15:0]     nonce_q;
    logic            done_q;

    logic            accept;
    logic            issue;
    logic            done_d;
    logic            pop;
    logic            final_hs;
    logic            can_issue;
    logic [1:0]      free;
    logic [2:0]      avail;
    logic [DLEN-1:0] synth_word;
    logic [DLEN-1:0] push_word;
    logic            push_last;

    assign busy = (state_q != ST_IDLE);
    assign done = done_q;
    assign Rho_prime_raddr = issue_idx_q[HLEN-1:0];

    assign pop = blk_valid & blk_ready;
    assign final_hs = pop & blk_last;

    // A slot freed by this cycle's handshake is usable by this cycle's
    // issue; without it the pipeline would only sustain half rate.
    // Buffered words plus the one in-flight read never exceed two.
    assign avail = {1'b0, free} + {2'b00, pop};
    assign can_issue = (avail > {2'b00, inflight_q});

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        issue   = 1'b0;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // done_q blocks a start arriving in the completion cycle.
                if (start && !done_q) begin
                    accept  = 1'b1;
                    state_d = ST_READ;
                end
            end
            ST_READ: begin
                if (can_issue) begin
                    issue = 1'b1;
                    if (issue_idx_q == SEED_LAST) begin
                        state_d = ST_TAIL;
                    end
                end
            end
            ST_TAIL: begin
                if (can_issue) begin
                    issue = 1'b1;
                    if (issue_idx_q == LAST_IDX) begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (final_hs) begin
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            issue_idx_q    <= '0;
            inflight_q     <= 1'b0;
            inflight_idx_q <= '0;
            nonce_q        <= '0;
            done_q         <= 1'b0;
        end else begin
            done_q     <= done_d;
            inflight_q <= issue;
            if (issue) begin
                inflight_idx_q <= issue_idx_q;
            end
            if (accept) begin
                nonce_q     <= nonce;
                issue_idx_q <= '0;
            end else if (issue) begin
                issue_idx_q <= issue_idx_q + 5'd1;
            end else if (done_d) begin
                issue_idx_q <= '0;
            end
        end
    end

    // Words past the seed are generated here and share the capture stage
    // with BRAM data, so they obey the same slot accounting.
    always_comb begin
        synth_word = '0;
        if (inflight_idx_q == NONCE_IDX) begin
            synth_word[15:0] = nonce_q;
`ifdef RHO_READER_PAD_EN
            synth_word[23:16] = SHAKE256_DS;
`endif
        end
`ifdef RHO_READER_PAD_EN
        if (inflight_idx_q == LAST_IDX) begin
            synth_word[DLEN-1 -: 8] = PAD_END;
        end
`endif
    end

    assign push_word = (inflight_idx_q < NONCE_IDX) ? Rho_prime_dout : synth_word;
    assign push_last = (inflight_idx_q == LAST_IDX);

    rho_skid_buf #(
        .DLEN(DLEN),
        .IW  (5)
    ) u_skid (
        .clk       (clk),
        .reset     (reset),
        .push      (inflight_q),
        .push_word (push_word),
        .push_idx  (inflight_idx_q),
        .push_last (push_last),
        .out_word  (blk_word),
        .out_idx   (blk_idx),
        .out_last  (blk_last),
        .out_valid (blk_valid),
        .out_ready (blk_ready),
        .free      (free)
    );

endmodule

// File: tb/tb_rho_prime_reader.sv
// tb/tb_rho_prime_reader.sv - scoreboard bench for rho_prime_reader
module tb_rho_prime_reader;

    localparam int DLEN = 64;
    localparam int HLEN = 3;
`ifdef RHO_READER_PAD_EN
    localparam int NW = 17;
    localparam int RST_AT = 10;
`else
    localparam int NW = 9;
    localparam int RST_AT = 6;
`endif
    localparam int DONE_LAT = NW + 2;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            start = 1'b0;
    logic [15:0]     nonce = 16'h0;
    logic            busy;
    logic            done;
    logic [HLEN-1:0] raddr;
    logic [DLEN-1:0] dout = '0;
    logic [DLEN-1:0] blk_word;
    logic [4:0]      blk_idx;
    logic            blk_valid;
    logic            blk_ready = 1'b1;
    logic            blk_last;

    logic [63:0] mem [8];

    typedef struct packed {
        logic [63:0] w;
        logic [4:0]  idx;
        logic        last;
    } exp_t;
    exp_t sb[$];

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int e0 = 0;
    int rdy_mode = 0;
    bit lat_check = 1'b0;
    bit first_seen = 1'b1;
    int hs_blk = 0;
    int issued = 0;

    rho_prime_reader #(.DLEN(DLEN), .HLEN(HLEN)) dut (
        .clk             (clk),
        .reset           (rst_n),
        .start           (start),
        .nonce           (nonce),
        .busy            (busy),
        .done            (done),
        .Rho_prime_raddr (raddr),
        .Rho_prime_dout  (dout),
        .blk_word        (blk_word),
        .blk_idx         (blk_idx),
        .blk_valid       (blk_valid),
        .blk_ready       (blk_ready),
        .blk_last        (blk_last)
    );

    always #5 clk = ~clk;

    always @(posedge clk) dout <= mem[raddr];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: message = seed bytes ++ nonce (LE); SHAKE256 pad10*1 with
    // domain byte when padding is built in, else zero-filled to whole lanes.
    function automatic logic [63:0] model_word(input int k, input logic [15:0] n);
        logic [7:0] b [136];
        logic [63:0] w;
        for (int i = 0; i < 136; i++) b[i] = 8'h00;
        for (int i = 0; i < 64; i++) b[i] = mem[i / 8][8 * (i % 8) +: 8];
        b[64] = n[7:0];
        b[65] = n[15:8];
`ifdef RHO_READER_PAD_EN
        b[66] = b[66] | 8'h1F;
        b[135] = b[135] | 8'h80;
`endif
        w = '0;
        for (int j = 0; j < 8; j++) w[8 * j +: 8] = b[8 * k + j];
        return w;
    endfunction

    // Clock counter and ready generator.
    initial begin
        forever begin
            @(posedge clk);
            cyc = cyc + 1;
            #1;
            case (rdy_mode)
                0: blk_ready = 1'b1;
                1: blk_ready = ~blk_ready;
                2: blk_ready = ((cyc - e0) >= 20);
                default: blk_ready = ($urandom_range(0, 3) != 0);
            endcase
        end
    end

    // Monitor: pops scoreboard on each handshake, checks stall stability,
    // read-ahead bound, first-valid and done timing.
    logic [DLEN-1:0] pw;
    logic [4:0]      pi;
    logic            pl;
    logic [HLEN-1:0] prev_raddr = '0;
    bit              prev_stall = 1'b0;
    bit              prev_done = 1'b0;
    exp_t            e;

    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_stall = 1'b0;
                prev_done = 1'b0;
                prev_raddr = '0;
                continue;
            end
            if (busy && raddr != prev_raddr) issued++;
            prev_raddr = raddr;
            if (busy) check("reads_ahead_le2", 64'((issued - hs_blk) <= 2), 64'd1);
            if (prev_stall) begin
                check("stall_valid", 64'(blk_valid), 64'd1);
                check("stall_word", blk_word, pw);
                check("stall_idx", 64'(blk_idx), 64'(pi));
                check("stall_last", 64'(blk_last), 64'(pl));
            end
            prev_stall = blk_valid && !blk_ready;
            pw = blk_word;
            pi = blk_idx;
            pl = blk_last;
            if (blk_valid && !first_seen) begin
                first_seen = 1'b1;
                check("first_valid_cycle", 64'(cyc - e0), 64'd2);
            end
            if (blk_valid && blk_ready) begin
                if (sb.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL sb_underflow: got word idx %0d, expected no word", blk_idx);
                end else begin
                    e = sb.pop_front();
                    check("blk_word", blk_word, e.w);
                    check("blk_idx", 64'(blk_idx), 64'(e.idx));
                    check("blk_last", 64'(blk_last), 64'(e.last));
                end
                hs_blk++;
            end
            if (done) begin
                check("done_busy_low", 64'(busy), 64'd0);
                check("done_single_pulse", 64'(prev_done), 64'd0);
                check("done_sb_empty", 64'(sb.size()), 64'd0);
                if (lat_check) check("done_latency", 64'(cyc - e0), 64'(DONE_LAT));
            end
            prev_done = done;
        end
    end

    task automatic launch(input logic [15:0] n);
        @(posedge clk);
        #1;
        for (int k = 0; k < NW; k++) sb.push_back('{model_word(k, n), 5'(k), (k == NW - 1)});
        hs_blk = 0;
        issued = 0;
        start = 1'b1;
        nonce = n;
        @(posedge clk);
        #1;
        e0 = cyc;
        first_seen = 1'b0;
        start = 1'b0;
        nonce = 16'($urandom);
    endtask

    task automatic wait_done(input int budget);
        bit got = 1'b0;
        for (int k = 0; k < budget; k++) begin
            @(negedge clk);
            if (done) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) begin
            tests++;
            fails++;
            $display("FAIL done_timeout: got no done within %0d cycles, expected done", budget);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"}, 64'(busy), 64'd0);
        check({tag, "_done"}, 64'(done), 64'd0);
        check({tag, "_valid"}, 64'(blk_valid), 64'd0);
        check({tag, "_last"}, 64'(blk_last), 64'd0);
        check({tag, "_word"}, blk_word, 64'd0);
        check({tag, "_idx"}, 64'(blk_idx), 64'd0);
        check({tag, "_raddr"}, 64'(raddr), 64'd0);
    endtask

    task automatic load_pattern();
        for (int i = 0; i < 8; i++) mem[i] = 64'h0706050403020100 + 64'(i) * 64'h0808080808080808;
    endtask

    initial begin
        load_pattern();
        #2;
        check_reset_outputs("reset");
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;

        // Ready held high: exact latency, then a start in the done cycle.
        rdy_mode = 0;
        lat_check = 1'b1;
        launch(16'h0102);
        wait_done(200);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        check("start_on_done_ignored", 64'(busy), 64'd0);

        // Ready toggling every cycle.
        rdy_mode = 1;
        lat_check = 1'b0;
        launch(16'h0102);
        wait_done(200);

        // Ready low for 20 cycles: two words buffered, address frozen.
        rdy_mode = 2;
        launch(16'h0102);
        repeat (6) @(negedge clk);
        check("stall5_raddr", 64'(raddr), 64'd2);
        check("stall5_idx", 64'(blk_idx), 64'd0);
        repeat (10) @(negedge clk);
        check("stall15_raddr", 64'(raddr), 64'd2);
        check("stall15_valid", 64'(blk_valid), 64'd1);
        wait_done(200);

        // Extra starts while busy are ignored; original nonce is emitted.
        rdy_mode = 0;
        lat_check = 1'b1;
        launch(16'h0102);
        repeat (4) @(posedge clk);
        #1 begin start = 1'b1; nonce = 16'hFFFF; end
        @(posedge clk);
        #1 start = 1'b0;
        repeat (3) @(posedge clk);
        #1 begin start = 1'b1; nonce = 16'hFFFF; end
        @(posedge clk);
        #1 start = 1'b0;
        wait_done(200);
        repeat (25) @(negedge clk);
        check("no_restart_busy", 64'(busy), 64'd0);

        // Reset mid-block, then a fresh block.
        launch(16'h0102);
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            #2;
            if (hs_blk >= RST_AT) break;
        end
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midreset");
        sb.delete();
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        launch(16'h0304);
        wait_done(200);

        // Randomized seeds, nonces and backpressure.
        lat_check = 1'b0;
        rdy_mode = 3;
        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < 8; i++) mem[i] = {$urandom, $urandom};
            launch(16'($urandom));
            wait_done(300);
        end

        repeat (3) @(negedge clk);
        check("final_sb_empty", 64'(sb.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
